// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA controller, the CPU and the shared memory bus.
// The slave modport is the controller's view; master is the system (CPU + memories).
interface oam_dma_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_w;
   logic        cpu_write_enable;
   logic [7:0]  cpu_data_r;
   logic [15:0] bus_addr;
   logic [7:0]  bus_data_w;
   logic        bus_write_enable;
   logic [7:0]  bus_data_r;
   logic        dma_active;

   modport master (
      output cpu_addr, cpu_data_w, cpu_write_enable, bus_data_r,
      input  cpu_data_r, bus_addr, bus_data_w, bus_write_enable, dma_active
   );

   modport slave (
      input  cpu_addr, cpu_data_w, cpu_write_enable, bus_data_r,
      output cpu_data_r, bus_addr, bus_data_w, bus_write_enable, dma_active
   );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA controller: a write to REG_ADDR copies LENGTH bytes from page src_hi
// to DST_BASE, one read cycle then one write cycle per byte, owning the bus meanwhile.
module oam_dma #(
   parameter logic [15:0] REG_ADDR    = 16'hFF46,
   parameter logic [15:0] DST_BASE    = 16'hFE00,
   parameter int unsigned LENGTH      = 160,
   parameter int unsigned START_DELAY = 2
) (
   input  logic       clk,
   input  logic       reset,
   oam_dma_if.slave   io
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   localparam int unsigned DELAY_W = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
   localparam logic [DELAY_W-1:0] DELAY_INIT = DELAY_W'(START_DELAY);
   localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);
   localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

   logic [1:0]         state;
   logic [1:0]         state_nx;
   logic [7:0]         src_hi;
   logic [7:0]         idx;
   logic [7:0]         byte_buf;
   logic [DELAY_W-1:0] delay;
   logic               active_q;
   logic               reg_hit;
   logic               trigger;
   logic [7:0]         src_mirror;

   assign reg_hit = (io.cpu_addr == REG_ADDR);
   assign trigger = io.cpu_write_enable && reg_hit;

   // Pages E0..FF are the echo of C0..DF, so fold them back before use.
   assign src_mirror = (io.cpu_data_w >= 8'hE0) ? io.cpu_data_w - 8'h20 : io.cpu_data_w;

   // A trigger restarts the sequence from any state, including mid-copy.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first; a path
      // that leaves it unassigned would infer a latch.
      state_nx = state;
      if (trigger) begin
         state_nx = ST_START;
      end else begin
         case (state)
            ST_START: if (delay == DELAY_ONE) state_nx = ST_READ;
            ST_READ:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = (idx == LAST_IDX) ? ST_IDLE : ST_READ;
            default:  state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state    <= ST_IDLE;
         src_hi   <= 8'hFF;
         idx      <= 8'h00;
         delay    <= '0;
         byte_buf <= 8'h00;
         active_q <= 1'b0;
      end else begin
         state    <= state_nx;
         active_q <= (state_nx != ST_IDLE);
         if (trigger) begin
            src_hi <= src_mirror;
            idx    <= 8'h00;
            delay  <= DELAY_INIT;
         end else begin
            case (state)
               ST_START: delay    <= delay - DELAY_ONE;
               ST_READ:  byte_buf <= io.bus_data_r;
               ST_WRITE: idx      <= idx + 8'd1;
               default:  ;
            endcase
         end
      end
   end

   // Bus mux: CPU passthrough when idle, DMA addresses while copying.
   // The write that is already on the bus during a retrigger still commits.
   always_comb begin
      io.bus_addr         = io.cpu_addr;
      io.bus_data_w       = io.cpu_data_w;
      io.bus_write_enable = 1'b0;
      io.cpu_data_r       = 8'hFF;
      case (state)
         ST_IDLE: begin
            io.bus_write_enable = io.cpu_write_enable && !reg_hit;
            io.cpu_data_r       = io.bus_data_r;
         end
         ST_READ: begin
            io.bus_addr = {src_hi, idx};
         end
         ST_WRITE: begin
            io.bus_addr         = DST_BASE + {8'h00, idx};
            io.bus_data_w       = byte_buf;
            io.bus_write_enable = 1'b1;
         end
         default: ;
      endcase
      if (reg_hit) io.cpu_data_r = src_hi;
      // Reset aborts at once: the byte in flight during reset is not written.
      if (reset) io.bus_write_enable = 1'b0;
   end

   assign io.dma_active = active_q;
endmodule
